// File: rtl/fifo_rd_pack_if.sv
// Byte-FIFO read side and packed-word output handshake of fifo_rd_pack.
// master is the packer's view; slave is the FIFO/consumer side.
interface fifo_rd_pack_if;
    logic        empty;
    logic [7:0]  q;
    logic        rd;
    logic        flush;
    logic [31:0] dout;
    logic [2:0]  dout_cnt;
    logic        dout_valid;
    logic        dout_ready;

    modport master (
        input  empty, q, flush, dout_ready,
        output rd, dout, dout_cnt, dout_valid
    );

    modport slave (
        output empty, q, flush, dout_ready,
        input  rd, dout, dout_cnt, dout_valid
    );
endinterface

// File: rtl/fifo_rd_pack.sv
// Packs bytes read from an upstream FIFO into 32-bit words, first byte in lane 0.
// A flush emits a partially filled word once the FIFO has run dry.
//
// state  | meaning
// S_FILL | request a byte (rd) when FIFO not empty; flush a partial word when idle
// S_CAPT | latch q into lane cnt, advance cnt
// S_OUT  | present word, hold until dout_ready
module fifo_rd_pack (
    input  logic            rdclk,
    input  logic            rst_n,
    fifo_rd_pack_if.master  bus
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_CAPT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] dout_q, dout_d;
    logic        rd_d;
    logic [4:0]  lane_lsb;

    assign lane_lsb = {cnt_q[1:0], 3'b000};

    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            cnt_q   <= 3'd0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rd_d    = 1'b0;
        case (state_q)
            S_FILL: begin
                // A pending flush waits until no more bytes are available.
                if (!bus.empty) begin
                    rd_d    = 1'b1;
                    state_d = S_CAPT;
                end else if (bus.flush && (cnt_q != 3'd0)) begin
                    state_d = S_OUT;
                end
            end
            S_CAPT: begin
                dout_d[lane_lsb +: 8] = bus.q;
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'd3) ? S_OUT : S_FILL;
            end
            S_OUT: begin
                if (bus.dout_ready) begin
                    dout_d  = 32'h0;
                    cnt_d   = 3'd0;
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    assign bus.rd         = rd_d & rst_n;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = (state_q == S_OUT);
    assign bus.dout_cnt   = (state_q == S_OUT) ? cnt_q : 3'd0;

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Directed bench for fifo_rd_pack: a byte-queue FIFO model feeds the packer,
// accepted words are collected and compared against hand-computed values.
module tb_fifo_rd_pack;

    logic rdclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 rdclk = ~rdclk;

    fifo_rd_pack_if bus();

    fifo_rd_pack dut (
        .rdclk (rdclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  fifo[$];
    int          fifo_sz = 0;
    logic        stall = 1'b0;
    assign bus.empty = (fifo_sz == 0) || stall;

    int          n_tests = 0;
    int          n_fail = 0;
    int          rd_pulses = 0;
    int          rd_bad = 0;
    int          cnt_bad = 0;
    logic [31:0] outq[$];
    logic [2:0]  cntq[$];

    // Upstream FIFO model: q becomes valid the cycle after an accepted read.
    always @(posedge rdclk) begin
        if (bus.dout_valid && bus.dout_ready) begin
            outq.push_back(bus.dout);
            cntq.push_back(bus.dout_cnt);
        end
        if (bus.rd && !bus.empty) begin
            rd_pulses++;
            #1;
            bus.q   = fifo.pop_front();
            fifo_sz = fifo.size();
        end
    end

    always @(negedge rdclk) begin
        if (bus.rd && bus.empty) rd_bad++;
        if (!rst_n && bus.rd) rd_bad++;
        if (!bus.dout_valid && bus.dout_cnt != 3'd0) cnt_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        fifo_sz = fifo.size();
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge rdclk);
    endtask

    task automatic clear_outs();
        outq.delete();
        cntq.delete();
    endtask

    task automatic wait_outs(input int n, input int budget);
        int k = 0;
        while (outq.size() < n && k < budget) begin
            @(negedge rdclk);
            k++;
        end
        if (outq.size() < n) chk("timeout_outs", outq.size(), n);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!bus.dout_valid && k < budget) begin
            @(negedge rdclk);
            k++;
        end
        if (!bus.dout_valid) chk("timeout_valid", 32'(bus.dout_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          base;
        logic        bad;
        logic [31:0] held;

        bus.q          = 8'h00;
        bus.flush      = 1'b0;
        bus.dout_ready = 1'b0;

        // Reset with data waiting: nothing may be read
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        cyc(3);
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_dout", bus.dout, 32'h0);
        chk("rst_cnt", 32'(bus.dout_cnt), 0);
        chk("rst_rd", 32'(bus.rd), 0);

        // Full word, ready high
        bus.dout_ready = 1'b1;
        base  = rd_pulses;
        rst_n = 1'b1;
        wait_outs(1, 40);
        cyc(5);
        chk("word1_dout", outq[0], 32'h44332211);
        chk("word1_cnt", 32'(cntq[0]), 4);
        chk("word1_rd_pulses", rd_pulses - base, 4);
        chk("word1_count", outq.size(), 1);

        // Backpressure: hold for 10 cycles with more data waiting
        clear_outs();
        bus.dout_ready = 1'b0;
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        wait_valid(40);
        held = bus.dout;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        bad = 1'b0;
        repeat (10) begin
            @(negedge rdclk);
            if (!bus.dout_valid || bus.dout !== held || bus.rd || bus.dout_cnt !== 3'd4) bad = 1'b1;
        end
        chk("hold_stable", 32'(bad), 0);
        chk("hold_dout", held, 32'hD4C3B2A1);
        chk("hold_no_xfer", outq.size(), 0);
        bus.dout_ready = 1'b1;
        @(negedge rdclk);
        chk("hold_accept_count", outq.size(), 1);
        chk("hold_valid_drop", 32'(bus.dout_valid), 0);
        chk("hold_accept_dout", outq[0], 32'hD4C3B2A1);
        wait_outs(2, 40);
        chk("after_hold_dout", outq[1], 32'h04030201);

        // Flush with nothing buffered is ignored, then partial flush
        cyc(5);
        clear_outs();
        bus.flush = 1'b1;
        cyc(10);
        chk("flush_empty_none", outq.size(), 0);
        chk("flush_empty_valid", 32'(bus.dout_valid), 0);
        bus.flush = 1'b0;
        push(8'h55); push(8'h66);
        cyc(8);
        chk("partial_no_out", outq.size(), 0);
        bus.flush = 1'b1;
        wait_outs(1, 20);
        bus.flush = 1'b0;
        chk("partial_dout", outq[0], 32'h00006655);
        chk("partial_cnt", 32'(cntq[0]), 2);
        cyc(5);
        chk("partial_count", outq.size(), 1);

        // Idle FIFO for 50 cycles
        clear_outs();
        base = rd_pulses;
        bad  = 1'b0;
        repeat (50) begin
            @(negedge rdclk);
            if (bus.rd || bus.dout_valid) bad = 1'b1;
        end
        chk("idle_quiet", 32'(bad), 0);
        chk("idle_rd_pulses", rd_pulses - base, 0);

        // Reset mid-word discards captured bytes
        push(8'hEE); push(8'hEF); push(8'hF0);
        cyc(8);
        rst_n = 1'b0;
        cyc(2);
        chk("midrst_dout", bus.dout, 32'h0);
        chk("midrst_valid", 32'(bus.dout_valid), 0);
        rst_n = 1'b1;
        push(8'h77); push(8'h88); push(8'h99); push(8'hAA);
        wait_outs(1, 40);
        cyc(5);
        chk("midrst_count", outq.size(), 1);
        chk("midrst_word", outq[0], 32'hAA998877);
        chk("midrst_cnt", 32'(cntq[0]), 4);

        // 9-byte stream then flush
        clear_outs();
        for (int i = 1; i <= 9; i++) push(8'(i * 8'h11));
        wait_outs(2, 60);
        cyc(6);
        bus.flush = 1'b1;
        wait_outs(3, 20);
        bus.flush = 1'b0;
        chk("stream_w0", outq[0], 32'h44332211);
        chk("stream_w1", outq[1], 32'h88776655);
        chk("stream_w2", outq[2], 32'h00000099);
        chk("stream_c0", 32'(cntq[0]), 4);
        chk("stream_c2", 32'(cntq[2]), 1);
        cyc(5);
        chk("stream_count", outq.size(), 3);

        chk("rd_rules", rd_bad, 0);
        chk("cnt_zero_when_idle", cnt_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
